proc_control: RTL and testbench
===============================

PROC_CONTROL -- requirements
Module: proc_control

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed.
REQ-002 Clock  input  1  the single clock; all state updates on its rising edge.
REQ-003 Reset  input  1  reset; asynchronous, active-high.
REQ-004 Run  input  1  start request; sampled only in T0.
REQ-005 IR  input  9  instruction from the external IR register: IR[8:6] opcode, IR[5:3] Rx, IR[2:0] Ry.
REQ-006 IRin  output  1  load enable for the IR register.
REQ-007 Rin  output  [0:7]  one-hot register load enables; Rin[i] enables register R(7-i), so the bit string equals the binary one-hot of the register number.
REQ-008 Rout  output  [0:7]  one-hot bus drive enables, same ordering as Rin.
REQ-009 DINout, Gout  output  1 each  bus drive enables for DIN and G.
REQ-010 Ain, Gin  output  1 each  load enables for A and G.
REQ-011 AddSub  output  1  ALU op: 0 add, 1 subtract.
REQ-012 Done  output  1  one-cycle pulse in the final step of each instruction.

Function
REQ-013 The block SHALL hold a 2-bit time-step state Tstep in {T0,T1,T2,T3}; the outputs SHALL be combinational from Tstep, IR and Run.
REQ-014 In T0: IRin = Run, all other outputs 0; next state T1 if Run=1, else T0.
REQ-015 Opcode 000 (mv Rx,Ry), T1: Rout = onehot(Ry), Rin = onehot(Rx), Done = 1; next state T0.
REQ-016 Opcode 001 (mvi Rx,#D), T1: DINout = 1, Rin = onehot(Rx), Done = 1; next state T0.
REQ-017 Opcodes 010 (add) and 011 (sub), T1: Rout = onehot(Rx), Ain = 1; next state T2.
REQ-018 add/sub, T2: Rout = onehot(Ry), Gin = 1, AddSub = IR[6]; next state T3.
REQ-019 add/sub, T3: Gout = 1, Rin = onehot(Rx), Done = 1; next state T0.
REQ-020 Opcodes 100-111 SHALL execute as NOP: T1 with Done = 1 only; next state T0.
REQ-021 Outputs not listed for a step SHALL be 0; at most one bus source (Rout bit, DINout, Gout) SHALL be active in any cycle.
REQ-022 Run is ignored outside T0; deasserting Run mid-instruction SHALL NOT abort the instruction.
REQ-023 With Run held high, back-to-back instructions SHALL proceed with exactly one T0 cycle between them.
REQ-024 Rx = Ry SHALL be legal and decoded without special casing.
REQ-025 Latency: mv/mvi/NOP 2 cycles, add/sub 4 cycles, counted from the T0 with Run=1 through the Done cycle.

Reset
REQ-026 While Reset = 1, Tstep SHALL be T0 and every output SHALL be 0, including IRin regardless of Run.
REQ-027 Reset asserted mid-instruction SHALL abort immediately, with no Done and no further Rin; after release, execution restarts at T0.

Structure
REQ-028 Opcode encodings (MV, MVI, ADD, SUB) and the Tstep encodings SHALL be constants in the shared processor package.
REQ-029 The onehot() function SHALL be implemented by two instances of the team decoder dec3to8 (Rx and Ry fields), with En tied high; no other sub-modules.

Verification
REQ-030 Reset, then Run = 0 for 5 cycles -> all outputs 0, Tstep stays at T0.
REQ-031 IR = 001_010_000, Run pulse -> T0: IRin = 1; T1: DINout = 1, Rin = 00000100, Done = 1.
REQ-032 IR = 000_101_011 -> T1: Rout = 00001000, Rin = 00100000, Done = 1.
REQ-033 IR = 011_001_110 -> T1: Rout = 00000010, Ain = 1; T2: Rout = 01000000, Gin = 1, AddSub = 1; T3: Gout = 1, Rin = 00000010, Done = 1.
REQ-034 IR = 010_011_100 with Reset asserted during T2 -> all outputs 0 in the same cycle, no Done, T0 after release.
REQ-035 IR = 111_000_000 -> T1: Done = 1, Rin = Rout = 0; Run held high -> next IRin one cycle later.

Source files
------------

// File: rtl/proc_control_pkg.sv
// Shared processor constants: time-step encoding and opcodes.
package proc_control_pkg;

    typedef enum logic [1:0] {
        T0 = 2'd0,
        T1 = 2'd1,
        T2 = 2'd2,
        T3 = 2'd3
    } tstep_t;

    localparam logic [2:0] OP_MV  = 3'b000;
    localparam logic [2:0] OP_MVI = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;

endpackage

// File: rtl/proc_control_dec3to8.sv
// 3-to-8 one-hot decoder; Y[0:7] value equals 1 << W when enabled.
module dec3to8 (
    input  logic [2:0] W,
    input  logic       En,
    output logic [0:7] Y
);

    always_comb begin
        Y = En ? (8'b1 << W) : 8'b0;
    end

endmodule

// File: rtl/proc_control.sv
// Multi-cycle control unit: sequences mv/mvi/add/sub over T0..T3
// and drives register, bus and ALU enables.
module proc_control
    import proc_control_pkg::*;
(
    input  logic       Clock,
    input  logic       Reset,
    input  logic       Run,
    input  logic [8:0] IR,
    output logic       IRin,
    output logic [0:7] Rin,
    output logic [0:7] Rout,
    output logic       DINout,
    output logic       Gout,
    output logic       Ain,
    output logic       Gin,
    output logic       AddSub,
    output logic       Done
);

    tstep_t     r_tstep;
    tstep_t     w_next;
    logic [2:0] w_op;
    logic [0:7] w_rx_oh;
    logic [0:7] w_ry_oh;

    assign w_op = IR[8:6];

    dec3to8 u_dec_x (
        .W  (IR[5:3]),
        .En (1'b1),
        .Y  (w_rx_oh)
    );

    dec3to8 u_dec_y (
        .W  (IR[2:0]),
        .En (1'b1),
        .Y  (w_ry_oh)
    );

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_tstep <= T0;
        end else begin
            r_tstep <= w_next;
        end
    end

    // Reset gates outputs combinationally so IRin cannot follow Run during reset.
    always_comb begin
        w_next = r_tstep;
        IRin   = 1'b0;
        Rin    = '0;
        Rout   = '0;
        DINout = 1'b0;
        Gout   = 1'b0;
        Ain    = 1'b0;
        Gin    = 1'b0;
        AddSub = 1'b0;
        Done   = 1'b0;
        if (!Reset) begin
            unique case (r_tstep)
                T0: begin
                    IRin   = Run;
                    w_next = Run ? T1 : T0;
                end
                T1: begin
                    unique case (w_op)
                        OP_MV: begin
                            Rout   = w_ry_oh;
                            Rin    = w_rx_oh;
                            Done   = 1'b1;
                            w_next = T0;
                        end
                        OP_MVI: begin
                            DINout = 1'b1;
                            Rin    = w_rx_oh;
                            Done   = 1'b1;
                            w_next = T0;
                        end
                        OP_ADD, OP_SUB: begin
                            Rout   = w_rx_oh;
                            Ain    = 1'b1;
                            w_next = T2;
                        end
                        default: begin
                            Done   = 1'b1;
                            w_next = T0;
                        end
                    endcase
                end
                T2: begin
                    Rout   = w_ry_oh;
                    Gin    = 1'b1;
                    AddSub = IR[6];
                    w_next = T3;
                end
                T3: begin
                    Gout   = 1'b1;
                    Rin    = w_rx_oh;
                    Done   = 1'b1;
                    w_next = T0;
                end
                default: w_next = T0;
            endcase
        end
    end

endmodule

// File: tb/tb_proc_control.sv
// Randomized scoreboard bench for proc_control with a micro-step model.
module tb_proc_control;

    typedef struct packed {
        logic       irin;
        logic [7:0] rin;
        logic [7:0] rout;
        logic       dinout;
        logic       gout;
        logic       ain;
        logic       gin;
        logic       addsub;
        logic       done;
    } out_t;

    logic       clk = 1'b0;
    logic       Reset = 1'b1;
    logic       Run = 1'b0;
    logic [8:0] IR = '0;
    logic       IRin, DINout, Gout, Ain, Gin, AddSub, Done;
    logic [0:7] Rin, Rout;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    out_t exp_q[$];
    out_t pending[$];

    always #5 clk = ~clk;

    proc_control dut (
        .Clock  (clk),
        .Reset  (Reset),
        .Run    (Run),
        .IR     (IR),
        .IRin   (IRin),
        .Rin    (Rin),
        .Rout   (Rout),
        .DINout (DINout),
        .Gout   (Gout),
        .Ain    (Ain),
        .Gin    (Gin),
        .AddSub (AddSub),
        .Done   (Done)
    );

    function automatic logic [7:0] oh(input logic [2:0] n);
        logic [7:0] v;
        v = 8'd1 << n;
        return v;
    endfunction

    // Micro-step list for one instruction, after its T0 fetch.
    function automatic void build(input logic [8:0] ir);
        logic [2:0] op, x, y;
        out_t s;
        op = ir[8:6];
        x  = ir[5:3];
        y  = ir[2:0];
        s  = '0;
        if (op == 3'd0) begin
            s.rout = oh(y); s.rin = oh(x); s.done = 1'b1;
            pending.push_back(s);
        end else if (op == 3'd1) begin
            s.dinout = 1'b1; s.rin = oh(x); s.done = 1'b1;
            pending.push_back(s);
        end else if (op == 3'd2 || op == 3'd3) begin
            s.rout = oh(x); s.ain = 1'b1;
            pending.push_back(s);
            s = '0;
            s.rout = oh(y); s.gin = 1'b1; s.addsub = (op == 3'd3);
            pending.push_back(s);
            s = '0;
            s.gout = 1'b1; s.rin = oh(x); s.done = 1'b1;
            pending.push_back(s);
        end else begin
            s.done = 1'b1;
            pending.push_back(s);
        end
    endfunction

    task automatic cycle(input logic rst_i, input logic run_i,
                         input logic [8:0] ir_i);
        out_t e;
        @(posedge clk);
        #1;
        Reset = rst_i;
        Run   = run_i;
        IR    = ir_i;
        e = '0;
        if (rst_i) begin
            pending.delete();
        end else if (pending.size() > 0) begin
            e = pending.pop_front();
        end else begin
            e.irin = run_i;
            if (run_i) build(ir_i);
        end
        exp_q.push_back(e);
    endtask

    always @(negedge clk) begin
        out_t e, a;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = {IRin, Rin, Rout, DINout, Gout, Ain, Gin, AddSub, Done};
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL outputs cyc=%0d act=%h exp=%h", cyc, a, e);
            end
            checks++;
            if ($countones(Rout) + int'(DINout) + int'(Gout) > 1) begin
                errors++;
                $display("FAIL bus_sources cyc=%0d act=%0d exp<=1", cyc,
                         $countones(Rout) + int'(DINout) + int'(Gout));
            end
            cyc++;
        end
    end

    initial begin
        logic [8:0] cur_ir;
        logic       r;
        cycle(1'b1, 1'b1, 9'h1ff);
        cycle(1'b1, 1'b1, 9'h0aa);
        repeat (5) cycle(1'b0, 1'b0, 9'h055);
        cycle(1'b0, 1'b1, 9'b001_010_000);
        cycle(1'b0, 1'b0, 9'b001_010_000);
        cycle(1'b0, 1'b1, 9'b000_101_011);
        cycle(1'b0, 1'b1, 9'b000_101_011);
        cycle(1'b0, 1'b0, 9'b000_101_011);
        cycle(1'b0, 1'b1, 9'b011_001_110);
        cycle(1'b0, 1'b0, 9'b011_001_110);
        cycle(1'b0, 1'b1, 9'b011_001_110);
        cycle(1'b0, 1'b0, 9'b011_001_110);
        cycle(1'b0, 1'b1, 9'b010_011_100);
        cycle(1'b0, 1'b0, 9'b010_011_100);
        cycle(1'b1, 1'b0, 9'b010_011_100);
        cycle(1'b0, 1'b0, 9'b010_011_100);
        cycle(1'b0, 1'b0, 9'b010_011_100);
        cycle(1'b0, 1'b1, 9'b111_000_000);
        cycle(1'b0, 1'b1, 9'b111_000_000);
        cycle(1'b0, 1'b1, 9'b000_011_011);
        cycle(1'b0, 1'b1, 9'b000_011_011);
        cycle(1'b0, 1'b1, 9'b010_100_100);
        repeat (3) cycle(1'b0, 1'b0, 9'b010_100_100);
        cur_ir = 9'b010_100_100;
        for (int i = 0; i < 400; i++) begin
            if (pending.size() == 0) cur_ir = 9'($urandom);
            r = ($urandom_range(0, 3) != 0);
            cycle(($urandom_range(0, 59) == 0), r, cur_ir);
        end
        cycle(1'b0, 1'b0, cur_ir);
        repeat (3) @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain act=%0d exp=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
